data_sampling_mv: RTL and testbench
===================================

Name: data_sampling_mv

Overview:
- Parametrised successor to the UART RX data sampler: majority-vote oversampler that accepts any even prescale in a range and 1, 3 or 5 votes per bit.
- Sits between the RX edge/bit counter and the deserializer/parity/stop checkers.
- Flags bits whose votes disagree (noise) and flags unsupported configurations instead of silently never sampling.

Parameters:
- PRESCALE_W, 6, width of prescale and edge_cnt.
- MAX_VOTES, 5, largest supported vote count (odd); sets accumulator width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- RX_IN  in  1  serial line, already synchronous to clk
- data_samp_en  in  1  sampling enable from RX FSM
- prescale  in  PRESCALE_W  oversampling ratio (clocks per bit)
- votes_sel  in  2  00=1 vote, 01=3 votes, 10=5 votes, 11=reserved
- edge_cnt  in  PRESCALE_W  position within bit, 0..prescale-1, advances by 1 per clk while enabled
- sampled_bit  out  1  majority result of last completed bit
- sample_done  out  1  one-cycle pulse when sampled_bit is updated
- noise_flag  out  1  votes of last completed bit were not unanimous
- cfg_err  out  1  current prescale/votes_sel combination is unsupported

Behaviour:
- Reset: sampled_bit=0, sample_done=0, noise_flag=0, cfg_err=0, accumulators=0, config register=0 (invalid).
- Config decode is registered every clk and takes effect one clk after prescale/votes_sel change:
  - N = 1/3/5 from votes_sel; K = (N-1)/2; C = prescale>>1.
  - Window = edge_cnt in [C-K, C+K]; done edge D = C+K+1.
  - Valid iff prescale even, prescale >= 4, votes_sel != 11, N <= MAX_VOTES, and D <= prescale-1.
  - Examples: prescale 4 allows only N=1; prescale 8 allows N<=5.
- cfg_err = registered NOT valid; updates regardless of data_samp_en.
- Software must hold the config static while data_samp_en=1.
- Accumulation, when data_samp_en=1 and valid:
  - ones counter and sample counter (width clog2(MAX_VOTES+1)).
  - At edge_cnt == C-K: counters load {RX_IN, 1}, discarding previous contents.
  - At edge_cnt in (C-K, C+K]: ones += RX_IN, count += 1.
- Resolution at edge_cnt == D (enabled and valid):
  - sampled_bit <= (2*ones > N).
  - noise_flag <= (ones != 0 && ones != N).
  - sample_done <= 1.
  - Result appears the clk after edge_cnt == D, i.e. latency 1 clk after the done edge.
- All other cycles: sample_done <= 0; sampled_bit and noise_flag hold.
- Vote counts and done edges match the legacy sampler for its supported settings:
  - prescale 4, N=1: sample at 2, done at 3.
  - prescale 8/16/32, N=3: samples 3-5 / 7-9 / 15-17, done at 6 / 10 / 18.
- data_samp_en=0: counters clear, sample_done <= 0, sampled_bit/noise_flag hold.
  - A deassertion mid-window aborts that bit with no pulse.
- Invalid config: no accumulation, sample_done stays 0, outputs hold.
- Reset asserted mid-window: all state to reset values immediately; no pulse after release until a full new window completes.
- Re-enable mid-bit (edge_cnt already past C-K): no pulse for that bit, because count < N at D.
  - Resolution additionally requires count == N.

Decomposition:
- Shared package uart_rx_pkg:
  - vote-select encodings (VOTES_1, VOTES_3, VOTES_5) and the reserved code;
  - PRESCALE_W default; MIN_PRESCALE=4.
- One sub-module: samp_window_decode.
  - Registered decode of prescale/votes_sel into C-K, C+K, D, N, valid.
  - Reused by the future start-bit glitch checker.
- Top level holds the accumulators and the output registers.

Test Plan:
- prescale=8, votes_sel=01, RX_IN=1 at edge 3,4 and 0 at edge 5 -> sample_done pulse one clk after edge_cnt=6, sampled_bit=1, noise_flag=1.
- prescale=16, votes_sel=10, RX_IN=0 for edges 6-10 -> sample_done after edge 11, sampled_bit=0, noise_flag=0; repeat with all 1 -> sampled_bit=1.
- prescale=4, votes_sel=01 -> cfg_err=1 one clk later, no sample_done over 3 bits; switch to votes_sel=00 -> cfg_err=0, sample at edge 2, done after edge 3.
- prescale=7 or prescale=2 or votes_sel=11 -> cfg_err=1, sample_done never asserts.
- prescale=32, votes_sel=01: drop data_samp_en at edge 16, re-raise at next bit's edge 0 -> no pulse for the aborted bit, normal pulse after edge 18 of the next bit.
- Assert rst at edge 8 of a prescale=16 bit -> all outputs 0 immediately; release, next full bit yields exactly one sample_done.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: vote-select encodings and sampler sizing defaults.
package uart_rx_pkg;

  localparam int PRESCALE_W_DEF = 6;
  localparam int MIN_PRESCALE   = 4;

  typedef enum logic [1:0] {
    VOTES_1    = 2'b00,
    VOTES_3    = 2'b01,
    VOTES_5    = 2'b10,
    VOTES_RSVD = 2'b11
  } votes_sel_e;

endpackage

// File: rtl/samp_window_decode.sv
// Registered decode of prescale/votes_sel into the sampling window, done edge,
// vote count and a validity flag. Also reused by the start-bit glitch checker.
module samp_window_decode
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int MAX_VOTES  = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PRESCALE_W-1:0]            prescale,
  input  logic [1:0]                       votes_sel,
  output logic [PRESCALE_W-1:0]            win_lo,
  output logic [PRESCALE_W-1:0]            win_hi,
  output logic [PRESCALE_W-1:0]            done_edge,
  output logic [$clog2(MAX_VOTES+1)-1:0]   n_votes,
  output logic                             valid,
  output logic                             cfg_err
);

  localparam int CW = $clog2(MAX_VOTES + 1);

  logic [PRESCALE_W-1:0] win_lo_d, win_lo_q, win_hi_d, win_hi_q, done_edge_d, done_edge_q;
  logic [PRESCALE_W-1:0] c_half, k_half;
  logic [CW-1:0]         n_votes_d, n_votes_q;
  logic                  valid_d, valid_q, cfg_err_d, cfg_err_q;
  int                    n_int;

  always_comb begin
    n_int = 1;
    case (votes_sel_e'(votes_sel))
      VOTES_3: n_int = 3;
      VOTES_5: n_int = 5;
      default: n_int = 1;
    endcase
    c_half      = prescale >> 1;
    k_half      = PRESCALE_W'((n_int - 1) / 2);
    win_lo_d    = c_half - k_half;
    win_hi_d    = c_half + k_half;
    // c_half is at most half the prescale range, so done_edge cannot wrap
    done_edge_d = win_hi_d + PRESCALE_W'(1);
    n_votes_d   = CW'(n_int);
    valid_d     = !prescale[0]
                  && (prescale >= PRESCALE_W'(MIN_PRESCALE))
                  && (votes_sel != VOTES_RSVD)
                  && (n_int <= MAX_VOTES)
                  && (done_edge_d < prescale);
    cfg_err_d   = !valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_lo_q    <= '0;
      win_hi_q    <= '0;
      done_edge_q <= '0;
      n_votes_q   <= '0;
      valid_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      win_lo_q    <= win_lo_d;
      win_hi_q    <= win_hi_d;
      done_edge_q <= done_edge_d;
      n_votes_q   <= n_votes_d;
      valid_q     <= valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign win_lo    = win_lo_q;
  assign win_hi    = win_hi_q;
  assign done_edge = done_edge_q;
  assign n_votes   = n_votes_q;
  assign valid     = valid_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: rtl/data_sampling_mv.sv
// Majority-vote UART RX bit sampler with configurable prescale and 1/3/5 votes,
// reporting per-bit noise and unsupported configurations.
module data_sampling_mv
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int MAX_VOTES  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  data_samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            votes_sel,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  sample_done,
  output logic                  noise_flag,
  output logic                  cfg_err
);

  localparam int CW = $clog2(MAX_VOTES + 1);

  logic [PRESCALE_W-1:0] win_lo, win_hi, done_edge;
  logic [CW-1:0]         n_votes;
  logic                  valid;
  logic [CW-1:0]         ones_d, ones_q, cnt_d, cnt_q;
  logic                  sampled_bit_d, sampled_bit_q, sample_done_d, sample_done_q;
  logic                  noise_flag_d, noise_flag_q;

  samp_window_decode #(
    .PRESCALE_W (PRESCALE_W),
    .MAX_VOTES  (MAX_VOTES)
  ) u_decode (
    .clk       (clk),
    .rst       (rst),
    .prescale  (prescale),
    .votes_sel (votes_sel),
    .win_lo    (win_lo),
    .win_hi    (win_hi),
    .done_edge (done_edge),
    .n_votes   (n_votes),
    .valid     (valid),
    .cfg_err   (cfg_err)
  );

  always_comb begin
    ones_d        = ones_q;
    cnt_d         = cnt_q;
    sampled_bit_d = sampled_bit_q;
    noise_flag_d  = noise_flag_q;
    sample_done_d = 1'b0;
    if (!data_samp_en || !valid) begin
      ones_d = '0;
      cnt_d  = '0;
    end else begin
      if (edge_cnt == win_lo) begin
        ones_d = CW'(RX_IN);
        cnt_d  = CW'(1);
      end else if ((edge_cnt > win_lo) && (edge_cnt <= win_hi)) begin
        ones_d = ones_q + CW'(RX_IN);
        cnt_d  = cnt_q + CW'(1);
      end
      // A bit entered mid-window never collects all its votes, so it is dropped
      if ((edge_cnt == done_edge) && (cnt_q == n_votes)) begin
        sampled_bit_d = ({ones_q, 1'b0} > {1'b0, n_votes});
        noise_flag_d  = (ones_q != '0) && (ones_q != n_votes);
        sample_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_q        <= '0;
      cnt_q         <= '0;
      sampled_bit_q <= 1'b0;
      sample_done_q <= 1'b0;
      noise_flag_q  <= 1'b0;
    end else begin
      ones_q        <= ones_d;
      cnt_q         <= cnt_d;
      sampled_bit_q <= sampled_bit_d;
      sample_done_q <= sample_done_d;
      noise_flag_q  <= noise_flag_d;
    end
  end

  assign sampled_bit = sampled_bit_q;
  assign sample_done = sample_done_q;
  assign noise_flag  = noise_flag_q;

endmodule

// File: tb/tb_data_sampling_mv.sv
// Directed bench for data_sampling_mv: vector table of single-bit configurations
// plus hand sequences for enable abort and mid-window reset.
module tb_data_sampling_mv;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX_IN = 1'b0;
  logic       data_samp_en = 1'b0;
  logic [5:0] prescale = 6'd0;
  logic [1:0] votes_sel = 2'b00;
  logic [5:0] edge_cnt = 6'd0;
  logic       sampled_bit, sample_done, noise_flag, cfg_err;

  int total = 0;
  int bad = 0;

  data_sampling_mv #(.PRESCALE_W(6), .MAX_VOTES(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_IN        (RX_IN),
    .data_samp_en (data_samp_en),
    .prescale     (prescale),
    .votes_sel    (votes_sel),
    .edge_cnt     (edge_cnt),
    .sampled_bit  (sampled_bit),
    .sample_done  (sample_done),
    .noise_flag   (noise_flag),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          p;
    logic [1:0]  vs;
    logic [31:0] mask;
    int          nbits;
    int          exp_pulses;
    int          exp_edge;
    logic        exp_cfg;
    logic        exp_bit;
    logic        exp_noise;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Call at #1 after a posedge; drives one bit period, counting pulses.
  task automatic run_bit(input int p, input logic [31:0] mask, input int en_off,
                         output int pulses, output int pedge);
    pulses = 0;
    pedge  = -1;
    for (int e = 0; e < p; e++) begin
      edge_cnt     = 6'(e);
      RX_IN        = mask[e];
      data_samp_en = (en_off < 0) || (e < en_off);
      @(posedge clk);
      #1;
      if (sample_done) begin
        pulses++;
        pedge = e;
      end
    end
  endtask

  task automatic set_cfg(input int p, input logic [1:0] vs);
    data_samp_en = 1'b0;
    edge_cnt     = 6'd0;
    prescale     = 6'(p);
    votes_sel    = vs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses, pedge, sum;
    vecs[0]  = '{8,  2'b01, 32'h0000_0018, 1, 1, 6,  1'b0, 1'b1, 1'b1};
    vecs[1]  = '{16, 2'b10, 32'h0000_0000, 1, 1, 11, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16, 2'b10, 32'h0000_FFFF, 1, 1, 11, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4,  2'b01, 32'h0000_000F, 3, 0, 0,  1'b1, 1'b1, 1'b0};
    vecs[4]  = '{4,  2'b00, 32'h0000_000B, 1, 1, 3,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{7,  2'b00, 32'h0000_00FF, 2, 0, 0,  1'b1, 1'b0, 1'b0};
    vecs[6]  = '{2,  2'b00, 32'h0000_0003, 2, 0, 0,  1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8,  2'b11, 32'h0000_00FF, 2, 0, 0,  1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32, 2'b01, 32'h0003_0000, 1, 1, 18, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{8,  2'b10, 32'h0000_000C, 1, 1, 7,  1'b0, 1'b0, 1'b1};
    vecs[10] = '{6,  2'b10, 32'h0000_003F, 1, 0, 0,  1'b1, 1'b0, 1'b1};
    vecs[11] = '{32, 2'b00, 32'h0001_0000, 1, 1, 17, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{6,  2'b01, 32'h0000_0010, 1, 1, 5,  1'b0, 1'b0, 1'b1};

    #12;
    check("reset sampled_bit", int'(sampled_bit), 0);
    check("reset sample_done", int'(sample_done), 0);
    check("reset noise_flag",  int'(noise_flag),  0);
    check("reset cfg_err",     int'(cfg_err),     0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      set_cfg(vecs[i].p, vecs[i].vs);
      check($sformatf("v%0d cfg_err", i), int'(cfg_err), int'(vecs[i].exp_cfg));
      sum = 0;
      for (int b = 0; b < vecs[i].nbits; b++) begin
        run_bit(vecs[i].p, vecs[i].mask, -1, pulses, pedge);
        sum += pulses;
        if (vecs[i].exp_pulses > 0)
          check($sformatf("v%0d done edge", i), pedge, vecs[i].exp_edge);
      end
      check($sformatf("v%0d pulses", i), sum, vecs[i].nbits * vecs[i].exp_pulses);
      check($sformatf("v%0d sampled_bit", i), int'(sampled_bit), int'(vecs[i].exp_bit));
      check($sformatf("v%0d noise_flag", i), int'(noise_flag), int'(vecs[i].exp_noise));
    end

    // Enable dropped at edge 16 aborts the bit; next bit samples normally.
    set_cfg(32, 2'b01);
    run_bit(32, 32'hFFFF_FFFF, 16, pulses, pedge);
    check("abort pulses", pulses, 0);
    check("abort hold bit", int'(sampled_bit), 0);
    check("abort hold noise", int'(noise_flag), 1);
    run_bit(32, ~32'h0003_8000, -1, pulses, pedge);
    check("after abort pulses", pulses, 1);
    check("after abort edge", pedge, 18);
    check("after abort bit", int'(sampled_bit), 0);
    check("after abort noise", int'(noise_flag), 0);

    // Reset asserted at edge 8 of a prescale-16 bit.
    set_cfg(16, 2'b01);
    run_bit(16, 32'h0000_0180, -1, pulses, pedge);
    check("pre-reset pulses", pulses, 1);
    check("pre-reset edge", pedge, 10);
    check("pre-reset bit", int'(sampled_bit), 1);
    check("pre-reset noise", int'(noise_flag), 1);
    pulses = 0;
    for (int e = 0; e < 16; e++) begin
      edge_cnt     = 6'(e);
      RX_IN        = 1'b1;
      data_samp_en = 1'b1;
      if (e == 9) rst = 1'b1;
      if (e == 8) begin
        #2;
        rst = 1'b0;
        #1;
        check("mid reset bit", int'(sampled_bit), 0);
        check("mid reset noise", int'(noise_flag), 0);
        check("mid reset done", int'(sample_done), 0);
        check("mid reset cfg_err", int'(cfg_err), 0);
      end
      @(posedge clk);
      #1;
      if (sample_done) pulses++;
    end
    check("reset bit pulses", pulses, 0);
    run_bit(16, 32'hFFFF_FFFF, -1, pulses, pedge);
    check("post-reset pulses", pulses, 1);
    check("post-reset edge", pedge, 10);
    check("post-reset bit", int'(sampled_bit), 1);
    check("post-reset noise", int'(noise_flag), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
